// File: rtl/cnn_operand_loader.sv
// cnn_operand_loader: deserialises a per-frame byte stream onto the CNN operand
// buses, strobes the frame, waits the fixed pipeline latency, captures the
// pooled result and hands it back to the host over valid/ready.
module cnn_operand_loader #(
   parameter int N_IN     = 16,
   parameter int N_K      = 4,
   parameter int DW       = 8,
   parameter int RW       = 16,
   parameter int PIPE_LAT = 3
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [DW-1:0]           S_Data,
   input  logic                    S_Valid,
   input  logic                    S_Last,
   output logic                    S_Ready,
   output logic [N_IN*DW-1:0]      In_Bus,
   output logic [N_K*N_IN*DW-1:0]  W_Bus,
   output logic                    Frame_Valid,
   input  logic [RW-1:0]           Res_In,
   output logic [RW-1:0]           Result,
   output logic                    Result_Valid,
   input  logic                    Result_Ready,
   output logic                    Frame_Err
);

   localparam int TOTAL = N_IN * (N_K + 1);
   localparam int CW    = $clog2(TOTAL);
   localparam int LW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

   typedef enum logic [1:0] {FILL, ISSUE, WAIT, HOLD} state_e;

   state_e                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [LW-1:0]              lat_q, lat_d;
   logic                       s_ready_q, s_ready_d;
   logic                       frame_valid_q, frame_valid_d;
   logic                       frame_err_q, frame_err_d;
   logic [RW-1:0]              result_q, result_d;
   logic                       result_valid_q, result_valid_d;
   // One flat operand store: slots 0..N_IN-1 are inputs, the rest are
   // weights in kernel-major order, so the byte index is the slot index.
   logic [TOTAL-1:0][DW-1:0]   ops_q, ops_d;
   logic                       accept;

   // s_ready_q is only ever high in FILL, so it alone qualifies a byte.
   assign accept = S_Valid & s_ready_q;

   // Next-state, byte placement, latency count and result capture.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      lat_d          = lat_q;
      s_ready_d      = s_ready_q;
      frame_valid_d  = 1'b0;
      frame_err_d    = 1'b0;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      ops_d          = ops_q;
      case (state_q)
         FILL: begin
            s_ready_d = 1'b1;
            if (accept) begin
               ops_d[cnt_q] = S_Data;
               if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
                  if (S_Last) begin
                     state_d       = ISSUE;
                     frame_valid_d = 1'b1;
                     s_ready_d     = 1'b0;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else if (S_Last) begin
                  // Early end of frame: restart, leave partial writes in place.
                  cnt_d       = '0;
                  frame_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ISSUE: begin
            lat_d   = LW'(PIPE_LAT - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (lat_q == '0) begin
               result_d       = Res_In;
               result_valid_d = 1'b1;
               state_d        = HOLD;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         HOLD: begin
            if (result_valid_q && Result_Ready) begin
               result_valid_d = 1'b0;
               s_ready_d      = 1'b1;
               state_d        = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State registers; reset wipes any frame in progress and all outputs.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q        <= FILL;
         cnt_q          <= '0;
         lat_q          <= '0;
         s_ready_q      <= 1'b0;
         frame_valid_q  <= 1'b0;
         frame_err_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         ops_q          <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lat_q          <= lat_d;
         s_ready_q      <= s_ready_d;
         frame_valid_q  <= frame_valid_d;
         frame_err_q    <= frame_err_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         ops_q          <= ops_d;
      end
   end

   assign S_Ready      = s_ready_q;
   assign Frame_Valid  = frame_valid_q;
   assign Frame_Err    = frame_err_q;
   assign Result       = result_q;
   assign Result_Valid = result_valid_q;
   assign In_Bus       = ops_q[N_IN-1:0];
   assign W_Bus        = ops_q[TOTAL-1:N_IN];

endmodule
